// File: rtl/iod_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and delay-line control payload for the
// IOD delay-line controller.
package iod_ctrl_pkg;

  localparam int unsigned CMD_OP_W     = 2;
  localparam int unsigned STATE_W      = 3;
  localparam int unsigned SETTLE_CNT_W = 4;
  localparam int unsigned MOVE_CNT_W   = 16;
  localparam int unsigned ERR_CNT_W    = 8;

  typedef enum logic [CMD_OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_NOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_MOVE   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } dly_state_e;

  // Registered controls presented to the IOD delay line
  typedef struct packed {
    logic move;
    logic direction;
    logic load;
  } dl_ctrl_t;

  function automatic logic op_is_step(input cmd_op_e op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/iod_dly_settle_tmr.sv
// Settle timer: loaded on the cycle before a settle window, counts down
// while enabled and flags the last cycle of the window.
module iod_dly_settle_tmr
  import iod_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire_c
);

  logic [SETTLE_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= SETTLE_CNT_W'(SETTLE - 1);
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - SETTLE_CNT_W'(1);
    end
  end

  assign o_expire_c = i_count && (r_cnt == '0);

endmodule

// File: rtl/iod_dly_ctrl.sv
// IOD delay-line tap controller: LOAD/INC/DEC/NOP commands become paced
// MOVE/LOAD pulses with tracked tap position. Optional counters: IOD_DLY_CTRL_STATS_EN.
module iod_dly_ctrl
  import iod_ctrl_pkg::*;
#(
  parameter int unsigned TAP_W    = 8,
  parameter int unsigned MAX_TAP  = 255,
  parameter int unsigned INIT_TAP = 1,
  parameter int unsigned SETTLE   = 4
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST_N,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [CMD_OP_W-1:0]   CMD_OP,
  input  logic [TAP_W-1:0]      CMD_STEPS,
  output logic                  DONE,
  output logic                  ERR,
  output logic [TAP_W-1:0]      TAP_POS,
  output logic                  DELAY_LINE_MOVE,
  output logic                  DELAY_LINE_DIRECTION,
  output logic                  DELAY_LINE_LOAD,
  input  logic                  DELAY_LINE_OUT_OF_RANGE
`ifdef IOD_DLY_CTRL_STATS_EN
  ,
  output logic [MOVE_CNT_W-1:0] MOVE_CNT,
  output logic [ERR_CNT_W-1:0]  ERR_CNT
`endif
);

  dly_state_e       r_state;
  dly_state_e       w_nxt_state;
  dl_ctrl_t         r_dl;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic             r_is_load;
  logic             r_oor;
  logic [TAP_W-1:0] r_tap;
  logic [TAP_W-1:0] r_steps;

  logic             w_nxt_dir;
  logic             w_nxt_err;
  logic             w_nxt_is_load;
  logic [TAP_W-1:0] w_nxt_tap;
  logic [TAP_W-1:0] w_nxt_steps;
  logic [TAP_W-1:0] w_step_tap;
  logic             w_accept;
  logic             w_at_limit;
  logic             w_tmr_load;
  logic             w_tmr_count;
  logic             w_tmr_expire;
  cmd_op_e          w_op;

  assign w_op       = cmd_op_e'(CMD_OP);
  assign w_accept   = CMD_VALID && r_ready;
  assign w_at_limit = r_dl.direction ? (r_tap == TAP_W'(MAX_TAP)) : (r_tap == '0);
  assign w_step_tap = r_dl.direction ? (r_tap + TAP_W'(1)) : (r_tap - TAP_W'(1));

  iod_dly_settle_tmr #(
    .SETTLE (SETTLE)
  ) u_settle_tmr (
    .i_clk      (FAB_CLK),
    .i_rst_n    (ARST_N),
    .i_load     (w_tmr_load),
    .i_count    (w_tmr_count),
    .o_expire_c (w_tmr_expire)
  );

  // Next-state and next-output decode
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_tap     = r_tap;
    w_nxt_steps   = r_steps;
    w_nxt_dir     = r_dl.direction;
    w_nxt_err     = 1'b0;
    w_nxt_is_load = r_is_load;
    w_tmr_load    = 1'b0;
    w_tmr_count   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt_steps   = CMD_STEPS;
          w_nxt_is_load = 1'b0;
          if (w_op == OP_LOAD) begin
            w_nxt_state   = ST_LOAD;
            w_nxt_tap     = TAP_W'(INIT_TAP);
            w_nxt_is_load = 1'b1;
          end else if (op_is_step(w_op) && (CMD_STEPS != '0)) begin
            w_nxt_state = ST_SETUP;
            w_nxt_dir   = (w_op == OP_INC);
          end else begin
            w_nxt_state = ST_DONE;
          end
        end
      end

      ST_SETUP: begin
        if (w_at_limit) begin
          w_nxt_state = ST_DONE;
          w_nxt_err   = 1'b1;
        end else begin
          w_nxt_state = ST_MOVE;
          w_nxt_tap   = w_step_tap;
          w_nxt_steps = r_steps - TAP_W'(1);
        end
      end

      ST_LOAD, ST_MOVE: begin
        w_nxt_state = ST_SETTLE;
        w_tmr_load  = 1'b1;
      end

      ST_SETTLE: begin
        w_tmr_count = 1'b1;
        // Range flag seen anywhere in the window aborts the remaining steps
        if (w_tmr_expire) begin
          if (r_is_load) begin
            w_nxt_state = ST_DONE;
          end else if (r_oor || DELAY_LINE_OUT_OF_RANGE) begin
            w_nxt_state = ST_DONE;
            w_nxt_err   = 1'b1;
          end else if (r_steps == '0) begin
            w_nxt_state = ST_DONE;
          end else if (w_at_limit) begin
            w_nxt_state = ST_DONE;
            w_nxt_err   = 1'b1;
          end else begin
            w_nxt_state = ST_MOVE;
            w_nxt_tap   = w_step_tap;
            w_nxt_steps = r_steps - TAP_W'(1);
          end
        end
      end

      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state   <= ST_IDLE;
      r_dl      <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_is_load <= 1'b0;
      r_tap     <= TAP_W'(INIT_TAP);
      r_steps   <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_dl.move    <= (w_nxt_state == ST_MOVE);
      r_dl.load    <= (w_nxt_state == ST_LOAD);
      r_dl.direction <= w_nxt_dir;
      r_ready      <= (w_nxt_state == ST_IDLE);
      r_done       <= (w_nxt_state == ST_DONE);
      r_err        <= w_nxt_err;
      r_is_load    <= w_nxt_is_load;
      r_tap        <= w_nxt_tap;
      r_steps      <= w_nxt_steps;
    end
  end

  // Sticky out-of-range flag, rearmed at the start of each settle window
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_oor <= 1'b0;
    end else if (w_tmr_load) begin
      r_oor <= 1'b0;
    end else if ((r_state == ST_SETTLE) && DELAY_LINE_OUT_OF_RANGE) begin
      r_oor <= 1'b1;
    end
  end

  assign CMD_READY            = r_ready;
  assign DONE                 = r_done;
  assign ERR                  = r_err;
  assign TAP_POS              = r_tap;
  assign DELAY_LINE_MOVE      = r_dl.move;
  assign DELAY_LINE_DIRECTION = r_dl.direction;
  assign DELAY_LINE_LOAD      = r_dl.load;

`ifdef IOD_DLY_CTRL_STATS_EN
  logic [MOVE_CNT_W-1:0] r_move_cnt;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  // Saturating pulse counters, cleared together with the tap on LOAD
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_move_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_nxt_state == ST_LOAD) begin
      r_move_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if ((w_nxt_state == ST_MOVE) && (r_move_cnt != '1)) begin
        r_move_cnt <= r_move_cnt + MOVE_CNT_W'(1);
      end
      if (w_nxt_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign MOVE_CNT = r_move_cnt;
  assign ERR_CNT  = r_err_cnt;
`endif

endmodule
